tick_divider: RTL and testbench
===============================

Name: tick_divider

Overview:
- Multi-channel, runtime-programmable rate generator. Replaces the fixed ripple-toggle divider chain.
- Produces single-cycle clock-enable ticks and square waves, all synchronous to the system clock. Downstream logic uses clock enables rather than derived clocks.
- Sits at top level. Feeds game timers, animation, sprite blink and seven-segment refresh.
- Supports continuous and one-shot (timer) mode per channel.

Parameters:
- NUM_CH, 4: number of independent channels.
- CNT_W, 28: counter and divisor width. Covers 1 Hz from 100 MHz.
- RESET_DIV, 100_000_000: divisor loaded into every channel at reset (1 Hz at 100 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  NUM_CH  per-channel count enable.
- load  in  NUM_CH  per-channel divisor load and re-arm strobe.
- div_in  in  NUM_CH*CNT_W  divisor values; channel i uses bits [i*CNT_W +: CNT_W].
- oneshot  in  NUM_CH  per-channel mode: 1 = one-shot, 0 = continuous.
- tick  out  NUM_CH  one-cycle pulse each period.
- sq  out  NUM_CH  square wave, period D.
- busy  out  NUM_CH  channel armed and enabled.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state changes on the rising edge of clk.
- Per-channel state:
  - D: divisor, CNT_W bits.
  - cnt: counter, CNT_W bits.
  - armed: 1 bit.
  - tick, sq: registered outputs.
- Reset: D=RESET_DIV, cnt=0, armed=1, tick=0, sq=0. busy is combinational and equals en & armed.
- Priority per channel, per edge: rst > load > count > hold.
- Load (load[i]=1):
  - D <= div_in slice; a value of 0 is stored as 1.
  - cnt <= 0, armed <= 1, tick <= 0, sq <= 0.
  - en is ignored in a load cycle.
- Count (en & armed, no load):
  - If cnt == D-1: cnt <= 0, tick <= 1, and armed <= 0 if oneshot[i] is 1.
  - Otherwise: cnt <= cnt+1, tick <= 0.
  - sq <= (next cnt >= (D>>1)). This gives sq low for floor(D/2) cycles and high for ceil(D/2) cycles.
- Hold (en=0 or armed=0):
  - cnt and sq hold; tick <= 0.
  - A disarmed one-shot channel stays at cnt=0 with tick=0 until the next load.
- Timing:
  - The first tick is high in the cycle after the D-th enabled edge, counted from cnt=0.
  - While en stays high, ticks repeat exactly every D cycles with no drift.
- D=1: tick is high every enabled cycle and sq stays 1.
- en deasserted mid-period: the phase is preserved and counting resumes from the held cnt.
- oneshot changed mid-period: takes effect at the next wrap.
- Reset mid-operation: all channels return to reset values on the next edge regardless of load or en.
- Width: comparisons are unsigned, CNT_W bits. D-1 is computed in CNT_W bits and is safe because D >= 1.
- Channels are fully independent; simultaneous events on different channels do not interact.
- All outputs are registered except busy.

Decomposition:
- Package tick_pkg:
  - CNT_W default.
  - CLK_HZ = 100_000_000.
  - Function hz_to_div(hz) = CLK_HZ/hz.
  - Named constants DIV_1HZ and DIV_10HZ (10_000_000).
- Sub-module tick_channel: one counter, divisor, armed flag and output registers.
- tick_divider: generate loop of NUM_CH tick_channel instances plus div_in slicing.

Test Plan:
- Reset, then en=1 on ch0 with a default-length sample (load 10 first): tick every 10 cycles exactly; sq low 5 cycles, high 5 cycles; busy=1.
- load ch1 with div_in=1: tick[1] high every cycle, sq[1]=1. Then load 0 -> identical behaviour (0 is clamped to 1).
- ch2 D=7, oneshot=1, en=1: exactly one tick 7 cycles after load, then busy=0 and no further ticks for 50 cycles. Pulse load -> one more tick 7 cycles later.
- ch0 D=8: deassert en for 5 cycles at cnt=3 -> tick arrives 13 cycles after the prior tick; subsequent ticks every 8 cycles.
- load and en asserted together with D=5 -> cnt=0 on the next edge, first tick 5 enabled edges later. rst asserted mid-count (cnt=3) -> next cycle cnt=0, tick=0, sq=0, D=RESET_DIV.
- All 4 channels loaded with 2, 3, 4, 5 simultaneously: tick counts over 60 cycles are 30, 20, 15, 12; channels are independent.

Source files
------------

// File: rtl/tick_pkg.sv
// Shared constants and helpers for the tick divider.
//   DEFAULT_CNT_W : default counter/divisor width
//   CLK_HZ        : system clock frequency
//   hz_to_div()   : divisor for a requested tick rate
//   DIV_1HZ, DIV_10HZ : common divisors
package tick_pkg;

  localparam int unsigned DEFAULT_CNT_W = 28;
  localparam int unsigned CLK_HZ        = 100_000_000;

  // Divisor that yields 'hz' ticks per second at CLK_HZ.
  function automatic int unsigned hz_to_div(input int unsigned hz);
    return CLK_HZ / hz;
  endfunction

  localparam int unsigned DIV_1HZ  = hz_to_div(1);
  localparam int unsigned DIV_10HZ = hz_to_div(10);

endpackage

// File: rtl/tick_divider_if.sv
// Control/status bundle of the tick divider.
//   en, load, oneshot : per-channel controls (master -> slave)
//   div_in            : packed per-channel divisors, channel i at [i*CNT_W +: CNT_W]
//   tick, sq, busy    : per-channel status (slave -> master)
interface tick_divider_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 28
);
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH-1:0]       oneshot;
  logic [NUM_CH*CNT_W-1:0] div_in;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       sq;
  logic [NUM_CH-1:0]       busy;

  modport master (output en, load, oneshot, div_in, input tick, sq, busy);
  modport slave  (input en, load, oneshot, div_in, output tick, sq, busy);
endinterface

// File: rtl/tick_channel.sv
// One rate-generator channel: divisor, counter, armed flag, tick/square outputs.
//   clk, rst : clock, synchronous active-high reset
//   en       : count enable
//   load     : load divisor and re-arm
//   oneshot  : 1 = disarm after the next wrap
//   div_in   : divisor to load (0 is treated as 1)
//   tick     : registered one-cycle pulse per period
//   sq       : registered square wave, low floor(D/2), high ceil(D/2)
//   busy     : combinational en & armed
module tick_channel
  import tick_pkg::*;
#(
  parameter int unsigned CNT_W     = DEFAULT_CNT_W,
  parameter int unsigned RESET_DIV = DIV_1HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             oneshot,
  input  logic [CNT_W-1:0] div_in,
  output logic             tick,
  output logic             sq,
  output logic             busy
);

  logic [CNT_W-1:0] d;
  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic             wrap;
  logic [CNT_W-1:0] cnt_nxt;

  // Terminal count detect; d is never 0 so d-1 cannot underflow.
  always_comb begin
    wrap    = (cnt == d - CNT_W'(1));
    cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
  end

  // Priority: rst > load > count > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      d     <= CNT_W'(RESET_DIV);
      cnt   <= '0;
      armed <= 1'b1;
      tick  <= 1'b0;
      sq    <= 1'b0;
    end else if (load) begin
      d     <= (div_in == '0) ? CNT_W'(1) : div_in;
      cnt   <= '0;
      armed <= 1'b1;
      tick  <= 1'b0;
      sq    <= 1'b0;
    end else if (en && armed) begin
      cnt  <= cnt_nxt;
      tick <= wrap;
      sq   <= (cnt_nxt >= (d >> 1));
      if (wrap && oneshot) begin
        armed <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  assign busy = en & armed;

endmodule

// File: rtl/tick_divider.sv
// Multi-channel programmable clock-enable generator.
//   clk, rst : clock, synchronous active-high reset
//   bus      : per-channel controls (en, load, oneshot, div_in) and
//              status (tick, sq registered; busy combinational)
module tick_divider
  import tick_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = DEFAULT_CNT_W,
  parameter int unsigned RESET_DIV = DIV_1HZ
) (
  input  logic           clk,
  input  logic           rst,
  tick_divider_if.slave  bus
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(
      .CNT_W     (CNT_W),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en[i]),
      .load    (bus.load[i]),
      .oneshot (bus.oneshot[i]),
      .div_in  (bus.div_in[i*CNT_W +: CNT_W]),
      .tick    (bus.tick[i]),
      .sq      (bus.sq[i]),
      .busy    (bus.busy[i])
    );
  end

endmodule

// File: tb/tb_tick_divider.sv
// Self-checking bench for tick_divider: vector table, directed corner
// sequences and randomized traffic against a period/phase reference model.
module tb_tick_divider;
  import tick_pkg::*;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = DEFAULT_CNT_W;
  localparam int unsigned RDIV   = DIV_1HZ;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tick_divider_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  tick_divider #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_DIV(RDIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: enabled edges since (re)arm, phase = edges mod D.
  int unsigned m_e    [NUM_CH];
  int unsigned m_d    [NUM_CH];
  bit          m_arm  [NUM_CH];
  bit          m_tick [NUM_CH];
  bit          m_sq   [NUM_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int unsigned dv;
    int unsigned ph;
    for (int c = 0; c < NUM_CH; c++) begin
      dv = int'(bus.div_in[c*CNT_W +: CNT_W]);
      if (rst) begin
        m_d[c] = RDIV; m_e[c] = 0; m_arm[c] = 1; m_tick[c] = 0; m_sq[c] = 0;
      end else if (bus.load[c]) begin
        m_d[c] = (dv == 0) ? 1 : dv; m_e[c] = 0; m_arm[c] = 1; m_tick[c] = 0; m_sq[c] = 0;
      end else if (bus.en[c] && m_arm[c]) begin
        m_e[c]++;
        ph = m_e[c] % m_d[c];
        m_tick[c] = (ph == 0);
        m_sq[c]   = (ph >= m_d[c] / 2);
        if (m_tick[c] && bus.oneshot[c]) m_arm[c] = 0;
      end else begin
        m_tick[c] = 0;
      end
    end
  endtask

  // Advance one edge; inputs are stable across the edge, outputs read 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic set_div(input int c, input int unsigned v);
    bus.div_in[c*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic check_model(input string tag);
    logic [NUM_CH-1:0] et, es, eb;
    for (int c = 0; c < NUM_CH; c++) begin
      et[c] = m_tick[c];
      es[c] = m_sq[c];
      eb[c] = bus.en[c] & m_arm[c];
    end
    check($sformatf("%s tick", tag), 32'(bus.tick), 32'(et));
    check($sformatf("%s sq", tag),   32'(bus.sq),   32'(es));
    check($sformatf("%s busy", tag), 32'(bus.busy), 32'(eb));
  endtask

  // Steps until tick[c] is seen; returns step count or -1 past the budget.
  task automatic steps_to_tick(input int c, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (bus.tick[c]) begin
        n = k;
        break;
      end
    end
  endtask

  typedef struct {
    bit ld;
    bit en;
    bit os;
    int unsigned dv;
    bit tk;
    bit sq;
    bit bz;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int n;
    int cnt_t [NUM_CH];

    bus.en = '0; bus.load = '0; bus.oneshot = '0; bus.div_in = '0;
    rst = 1'b1;
    step();
    step();
    check("reset tick", 32'(bus.tick), 32'h0);
    check("reset sq",   32'(bus.sq),   32'h0);
    check("reset busy idle", 32'(bus.busy), 32'h0);
    bus.en = '1;
    step();
    check("reset busy en", 32'(bus.busy), 32'hF);
    bus.en = '0;
    rst = 1'b0;

    // ch0 vector table: {load, en, oneshot, div, exp tick, exp sq, exp busy}
    tbl[0]  = '{1, 1, 0, 3, 0, 0, 1};
    tbl[1]  = '{0, 1, 0, 0, 0, 1, 1};
    tbl[2]  = '{0, 1, 0, 0, 0, 1, 1};
    tbl[3]  = '{0, 1, 0, 0, 1, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 1, 1};
    tbl[6]  = '{1, 1, 1, 2, 0, 0, 1};
    tbl[7]  = '{0, 1, 1, 0, 0, 1, 1};
    tbl[8]  = '{0, 1, 1, 0, 1, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 1, 0, 0, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 0, 1, 1, 1};
    tbl[12] = '{0, 1, 0, 0, 1, 1, 1};
    for (int i = 0; i < 13; i++) begin
      bus.load[0] = tbl[i].ld;
      bus.en[0] = tbl[i].en;
      bus.oneshot[0] = tbl[i].os;
      set_div(0, tbl[i].dv);
      step();
      check($sformatf("tbl[%0d] tick", i), 32'(bus.tick[0]), 32'(tbl[i].tk));
      check($sformatf("tbl[%0d] sq", i),   32'(bus.sq[0]),   32'(tbl[i].sq));
      check($sformatf("tbl[%0d] busy", i), 32'(bus.busy[0]), 32'(tbl[i].bz));
    end
    bus.en = '0; bus.load = '0; bus.oneshot = '0;

    // D=10 on ch0: tick every 10, sq low 5 / high 5
    set_div(0, 10); bus.load[0] = 1; bus.en[0] = 1;
    step();
    bus.load[0] = 0;
    steps_to_tick(0, 20, n);
    check("d10 first tick", 32'(n), 32'd10);
    begin
      int hi, tk;
      hi = 0; tk = 0;
      for (int k = 0; k < 10; k++) begin
        step();
        hi += int'(bus.sq[0]);
        tk += int'(bus.tick[0]);
      end
      check("d10 sq high cycles", 32'(hi), 32'd5);
      check("d10 ticks per 10", 32'(tk), 32'd1);
      check("d10 tick on 10th", 32'(bus.tick[0]), 32'd1);
      check("d10 busy", 32'(bus.busy[0]), 32'd1);
    end

    // D=1 on ch1
    set_div(1, 1); bus.load[1] = 1; bus.en[1] = 1;
    step();
    bus.load[1] = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("d1 tick", 32'(bus.tick[1]), 32'd1);
      check("d1 sq",   32'(bus.sq[1]),   32'd1);
    end

    // One-shot ch2 D=7
    set_div(2, 7); bus.oneshot[2] = 1; bus.load[2] = 1; bus.en[2] = 1;
    step();
    bus.load[2] = 0;
    steps_to_tick(2, 20, n);
    check("oneshot first tick", 32'(n), 32'd7);
    begin
      int tk;
      tk = 0;
      for (int k = 0; k < 50; k++) begin
        step();
        tk += int'(bus.tick[2]);
      end
      check("oneshot quiet ticks", 32'(tk), 32'd0);
      check("oneshot busy", 32'(bus.busy[2]), 32'd0);
    end
    bus.load[2] = 1;
    step();
    bus.load[2] = 0;
    steps_to_tick(2, 20, n);
    check("oneshot rearm tick", 32'(n), 32'd7);
    bus.en = '0; bus.oneshot = '0;

    // ch0 D=8 with a 5-cycle en gap at cnt=3
    set_div(0, 8); bus.load[0] = 1; bus.en[0] = 1;
    step();
    bus.load[0] = 0;
    steps_to_tick(0, 20, n);
    check("pause first tick", 32'(n), 32'd8);
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      bus.en[0] = (k >= 4 && k <= 8) ? 1'b0 : 1'b1;
      step();
      if (bus.tick[0]) begin
        n = k;
        break;
      end
    end
    check("pause gap", 32'(n), 32'd13);
    steps_to_tick(0, 20, n);
    check("pause resume period", 32'(n), 32'd8);
    bus.en = '0;

    // ch3 load+en together with D=5, then reset at cnt=3
    set_div(3, 5); bus.load[3] = 1; bus.en[3] = 1;
    step();
    bus.load[3] = 0;
    steps_to_tick(3, 20, n);
    check("load+en first tick", 32'(n), 32'd5);
    step(); step(); step();
    rst = 1'b1; bus.load[3] = 1;
    step();
    rst = 1'b0; bus.load[3] = 0;
    check("midrst tick", 32'(bus.tick), 32'h0);
    check("midrst sq",   32'(bus.sq),   32'h0);
    begin
      int tk, hi;
      tk = 0; hi = 0;
      for (int k = 0; k < 20; k++) begin
        step();
        tk += int'(bus.tick[3]);
        hi += int'(bus.sq[3]);
      end
      check("midrst long period ticks", 32'(tk), 32'd0);
      check("midrst long period sq", 32'(hi), 32'd0);
    end
    bus.en = '0;

    // All channels 2,3,4,5 simultaneously
    for (int c = 0; c < NUM_CH; c++) begin
      set_div(c, 32'(c + 2));
      cnt_t[c] = 0;
    end
    bus.load = '1; bus.en = '1;
    step();
    bus.load = '0;
    for (int k = 0; k < 60; k++) begin
      step();
      for (int c = 0; c < NUM_CH; c++) cnt_t[c] += int'(bus.tick[c]);
    end
    check("multi ch0 ticks", 32'(cnt_t[0]), 32'd30);
    check("multi ch1 ticks", 32'(cnt_t[1]), 32'd20);
    check("multi ch2 ticks", 32'(cnt_t[2]), 32'd15);
    check("multi ch3 ticks", 32'(cnt_t[3]), 32'd12);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        bus.load[c]    = ($urandom_range(0, 15) == 0);
        bus.en[c]      = ($urandom_range(0, 3) != 0);
        bus.oneshot[c] = ($urandom_range(0, 7) == 0);
        set_div(c, $urandom_range(0, 9));
      end
      step();
      check_model($sformatf("rand[%0d]", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
